rcp_avg_rtt_sched: RTL and testbench
====================================

# rcp_avg_rtt_sched

Periodic control-interval scheduler for the RCP router's rate computation. Every programmed interval it takes a consistent snapshot of each MAC port's RTT sum and RCP packet count. It then time-shares one sequential 64/32 divider across the ports in fixed order to produce per-port average RTT. It sits beside the RCP register block: it takes its interval and enable from software registers, its per-port statistics from the MAC-side counters, and feeds averages back for readout and rate computation.

## Interface
- NUM_PORTS, 4, number of MAC ports scheduled
- DATA_WIDTH, 32, register/quotient width
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ctrl_enable  in  1  scheduler enable
- interval  in  DATA_WIDTH  control interval in clk cycles; 0 = no ticks
- rtt_sum  in  NUM_PORTS*64  per-port {RTT_HI, RTT_LO}, port p at [64p+63:64p]
- num_rcp  in  NUM_PORTS*DATA_WIDTH  per-port RCP packet count
- avg_rtt  out  NUM_PORTS*DATA_WIDTH  per-port rtt_sum/num_rcp, saturated
- avg_valid  out  NUM_PORTS  port's avg_rtt came from a nonzero count
- update_done  out  1  one-cycle pulse when all ports are updated
- busy  out  1  high from SNAP through DONE
- overrun_cnt  out  DATA_WIDTH  ticks dropped while busy

## Operation
- Timer: cnt resets to 0. When ctrl_enable=1 and interval≠0, cnt increments each cycle.
  - tick = (cnt >= interval-1); on tick cnt returns to 0.
  - ">=" covers interval being lowered below the current cnt.
  - When ctrl_enable=0 or interval=0, cnt is held at 0 and no tick occurs.
- FSM states: IDLE, SNAP, DIV, STORE, DONE.
- IDLE: on tick go to SNAP.
- SNAP (1 cycle): latch all rtt_sum/num_rcp into shadow registers; set port index p=0.
- STORE decision per port:
  - If shadow num_rcp[p]==0: go directly to STORE; write avg_rtt[p]=0, avg_valid[p]=0.
  - Otherwise: load the divider and enter DIV.
- DIV: restoring divider, one quotient bit per cycle, 64 cycles.
- STORE (1 cycle): write avg_rtt[p] = (quotient > 2^32-1) ? 32'hFFFF_FFFF : quotient[31:0]; set avg_valid[p]=1.
  - If p==NUM_PORTS-1 go to DONE; otherwise p+1 goes to the zero-check/DIV.
- DONE (1 cycle): update_done=1; return to IDLE.
- Tick in any non-IDLE state: tick is dropped and overrun_cnt increments (wraps at 2^32).
- ctrl_enable deasserted mid-update: the current update completes; no further ticks occur.
- avg_rtt/avg_valid hold their values between updates. Ports are updated one by one within an update.
- Reset mid-operation: FSM returns to IDLE, all outputs are cleared, cnt=0, and the partial update is discarded.

## Timing
- Reset values: avg_rtt=0, avg_valid=0, update_done=0, busy=0, overrun_cnt=0.
- Sampling: tick in cycle t puts SNAP in t+1; inputs are sampled at the clk edge ending t+1.
- Per-port cost: nonzero port = 64 DIV + 1 STORE = 65 cycles; zero-count port = 1 cycle.
- Output timing:
  - avg_rtt[p] changes at the edge ending its STORE cycle.
  - update_done is high in cycle t+2+C, where C is the sum of per-port costs.
  - All 4 ports nonzero: update_done at t+262.
  - busy is high from t+1 through the DONE cycle inclusive.
- Minimum useful interval for NUM_PORTS=4 with all counts nonzero is 263; shorter intervals overrun.

## Configuration
- RCP_SCHED_OVERRUN_CNT_EN defined: overrun_cnt counts dropped ticks as above.
- RCP_SCHED_OVERRUN_CNT_EN undefined: overrun_cnt tied to 0 and the counter logic is omitted; dropped ticks are still dropped.

## Test plan
- Reset, then interval=300, enable=1.
  - Port0 rtt_sum=1000, num_rcp=10 → avg_rtt[0]=100, avg_valid[0]=1.
  - update_done pulses exactly 262 cycles after the first tick.
- Port1 num_rcp=0 → avg_rtt[1]=0, avg_valid[1]=0. Update completes 64 cycles sooner (t+198).
- Port2 rtt_sum=64'h0000_0002_0000_0000, num_rcp=1 → avg_rtt[2]=32'hFFFF_FFFF (saturation).
- interval=100 with all ports nonzero → each update still completes; overrun_cnt=2 after the first update (ticks at +100, +200 dropped).
  - Repeat with the macro undefined → overrun_cnt stays 0.
- Change rtt_sum[0] during DIV of port0 → result reflects the SNAP-cycle value only.
- Assert reset during DIV of port2 → all outputs return to 0 next cycle. With interval=300, the next update_done is 262 cycles after the first post-reset tick.

Source files
------------

// File: rtl/rcp_avg_rtt_sched.sv
// rcp_avg_rtt_sched: periodic per-port average RTT scheduler sharing one 64/32 divider.
// Optional overrun counter enabled by defining RCP_SCHED_OVERRUN_CNT_EN.
module rcp_avg_rtt_sched #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ctrl_enable,
    input  logic [DATA_WIDTH-1:0]           interval,
    input  logic [NUM_PORTS*64-1:0]         rtt_sum,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] num_rcp,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] avg_rtt,
    output logic [NUM_PORTS-1:0]            avg_valid,
    output logic                            update_done,
    output logic                            busy,
    output logic [DATA_WIDTH-1:0]           overrun_cnt
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SNAP,
        S_DIV,
        S_STORE,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [DATA_WIDTH-1:0] r_cnt;
    logic                  w_run;
    logic                  w_tick;

    logic [63:0]           r_sh_sum [NUM_PORTS];
    logic [DATA_WIDTH-1:0] r_sh_cnt [NUM_PORTS];

    logic [PW-1:0]         r_p;
    logic [PW-1:0]         w_p_nx;
    logic [5:0]            r_bit;

    logic [63:0]           r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_den;
    logic [DATA_WIDTH:0]   w_rem_sh;
    logic [DATA_WIDTH:0]   w_rem_sub;
    logic                  w_ge;
    logic [DATA_WIDTH-1:0] w_q_sat;

    logic [63:0]           w_ld_num;
    logic [DATA_WIDTH-1:0] w_ld_den;

    logic [NUM_PORTS*DATA_WIDTH-1:0] r_avg;
    logic [NUM_PORTS-1:0]            r_vld;

    assign w_run  = ctrl_enable && (interval != '0);
    assign w_tick = w_run && (r_cnt >= interval - 1'b1);

    // Interval timer: free-runs while enabled, restarts on every tick.
    always_ff @(posedge clk) begin
        if (reset || !w_run || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Control FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    assign w_p_nx = (r_p == LAST) ? '0 : r_p + 1'b1;

    // Divider operands for the port about to start; port 0 comes straight from the inputs.
    always_comb begin
        w_ld_num = r_sh_sum[w_p_nx];
        w_ld_den = r_sh_cnt[w_p_nx];
        if (r_state == S_SNAP) begin
            w_ld_num = rtt_sum[63:0];
            w_ld_den = num_rcp[DATA_WIDTH-1:0];
        end
    end

    // Next-state logic; zero-count ports skip the divider entirely.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_tick) begin
                    w_state_nx = S_SNAP;
                end
            end
            S_SNAP: begin
                w_state_nx = (w_ld_den != '0) ? S_DIV : S_STORE;
            end
            S_DIV: begin
                if (r_bit == 6'd63) begin
                    w_state_nx = S_STORE;
                end
            end
            S_STORE: begin
                if (r_p == LAST) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = (w_ld_den != '0) ? S_DIV : S_STORE;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign w_rem_sh  = {r_rem, r_quo[63]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_den});
    assign w_rem_sub = w_rem_sh - {1'b0, r_den};
    assign w_q_sat   = (|r_quo[63:DATA_WIDTH]) ? '1 : r_quo[DATA_WIDTH-1:0];

    // Snapshot, restoring divide steps and per-port result write-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p   <= '0;
            r_bit <= '0;
            r_quo <= '0;
            r_rem <= '0;
            r_den <= '0;
            r_avg <= '0;
            r_vld <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_sh_sum[i] <= '0;
                r_sh_cnt[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_SNAP: begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        r_sh_sum[i] <= rtt_sum[i*64 +: 64];
                        r_sh_cnt[i] <= num_rcp[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    r_p   <= '0;
                    r_quo <= w_ld_num;
                    r_den <= w_ld_den;
                    r_rem <= '0;
                    r_bit <= '0;
                end
                S_DIV: begin
                    r_quo <= {r_quo[62:0], w_ge};
                    r_rem <= w_ge ? w_rem_sub[DATA_WIDTH-1:0]
                                  : w_rem_sh[DATA_WIDTH-1:0];
                    r_bit <= r_bit + 6'd1;
                end
                S_STORE: begin
                    if (r_sh_cnt[r_p] == '0) begin
                        r_avg[r_p*DATA_WIDTH +: DATA_WIDTH] <= '0;
                        r_vld[r_p] <= 1'b0;
                    end else begin
                        r_avg[r_p*DATA_WIDTH +: DATA_WIDTH] <= w_q_sat;
                        r_vld[r_p] <= 1'b1;
                    end
                    r_p   <= w_p_nx;
                    r_quo <= w_ld_num;
                    r_den <= w_ld_den;
                    r_rem <= '0;
                    r_bit <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RCP_SCHED_OVERRUN_CNT_EN
    logic [DATA_WIDTH-1:0] r_ovr;

    // Count ticks that arrive while an update is still in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovr <= '0;
        end else if (w_tick && (r_state != S_IDLE)) begin
            r_ovr <= r_ovr + 1'b1;
        end
    end

    assign overrun_cnt = r_ovr;
`else
    assign overrun_cnt = '0;
`endif

    assign avg_rtt     = r_avg;
    assign avg_valid   = r_vld;
    assign update_done = (r_state == S_DONE);
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rcp_avg_rtt_sched.sv
// tb_rcp_avg_rtt_sched: directed scoreboard bench for rcp_avg_rtt_sched.
// Expected overrun counts follow RCP_SCHED_OVERRUN_CNT_EN.
module tb_rcp_avg_rtt_sched;

    localparam int NP = 4;
    localparam int DW = 32;
`ifdef RCP_SCHED_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ctrl_enable = 1'b0;
    logic [DW-1:0]     interval = '0;
    logic [NP*64-1:0]  rtt_sum = '0;
    logic [NP*DW-1:0]  num_rcp = '0;
    logic [NP*DW-1:0]  avg_rtt;
    logic [NP-1:0]     avg_valid;
    logic              update_done;
    logic              busy;
    logic [DW-1:0]     overrun_cnt;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int             cyc;
        logic [NP*DW-1:0] avg;
        logic [NP-1:0]  vld;
        logic [DW-1:0]  ovr;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    rcp_avg_rtt_sched #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_enable (ctrl_enable),
        .interval    (interval),
        .rtt_sum     (rtt_sum),
        .num_rcp     (num_rcp),
        .avg_rtt     (avg_rtt),
        .avg_valid   (avg_valid),
        .update_done (update_done),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, a, e, cyc);
        end
    endtask

    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_port(input int p, input logic [63:0] s, input logic [DW-1:0] n);
        rtt_sum[p*64 +: 64] = s;
        num_rcp[p*DW +: DW] = n;
    endtask

    task automatic set_base();
        set_port(0, 64'd1000, 32'd10);
        set_port(1, 64'd5000, 32'd3);
        set_port(2, 64'h0000_0002_0000_0000, 32'd1);
        set_port(3, 64'd12345678901, 32'd1000);
    endtask

    function automatic logic [NP*DW-1:0] mk(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                            input logic [DW-1:0] a2, input logic [DW-1:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic push(input int c, input logic [NP*DW-1:0] a, input logic [NP-1:0] v,
                        input logic [DW-1:0] o);
        exp_t e;
        e.cyc = c;
        e.avg = a;
        e.vld = v;
        e.ovr = o;
        q.push_back(e);
    endtask

    // Monitor: every update_done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (update_done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done act=cycle %0d exp=none", cyc);
            end else begin
                m_e = q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(m_e.cyc));
                for (int p = 0; p < NP; p++) begin
                    chk($sformatf("avg%0d", p), 64'(avg_rtt[p*DW +: DW]), 64'(m_e.avg[p*DW +: DW]));
                end
                chk("avg_valid", 64'(avg_valid), 64'(m_e.vld));
                chk("overrun", 64'(overrun_cnt), 64'(m_e.ovr));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [NP*DW-1:0] base_avg;
        logic [NP*DW-1:0] avg2;
        base_avg = mk(32'd100, 32'd1666, 32'hFFFF_FFFF, 32'd12345678);
        avg2     = mk(32'd9999, 32'd0, 32'hFFFF_FFFF, 32'd12345678);
        set_base();
        goto(3);
        chk("rst_avg", 64'(avg_rtt[63:0]), 64'd0);
        chk("rst_avg_hi", 64'(avg_rtt[127:64]), 64'd0);
        chk("rst_valid", 64'(avg_valid), 64'd0);
        chk("rst_done", 64'(update_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovr", 64'(overrun_cnt), 64'd0);

        // interval 300, all ports nonzero, then port1 count goes to zero
        reset = 1'b0;
        ctrl_enable = 1'b1;
        interval = 32'd300;
        t = cyc + 299;
        push(t + 262, base_avg, 4'hF, 32'd0);
        goto(t);
        chk("busy_tick", 64'(busy), 64'd0);
        goto(t + 1);
        chk("busy_snap", 64'(busy), 64'd1);
        goto(t + 20);
        set_port(0, 64'd99999, 32'd10);
        goto(t + 270);
        set_port(1, 64'd5000, 32'd0);
        push(t + 300 + 198, avg2, 4'b1101, 32'd0);
        goto(t + 500);
        ctrl_enable = 1'b0;
        goto(t + 900);
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("hold_avg%0d", p), 64'(avg_rtt[p*DW +: DW]), 64'(avg2[p*DW +: DW]));
        end
        chk("hold_valid", 64'(avg_valid), 64'(4'b1101));
        chk("drain1", 64'(q.size()), 64'd0);

        // interval 100: overruns, enable dropped mid-update
        reset = 1'b1;
        set_base();
        goto(cyc + 2);
        reset = 1'b0;
        ctrl_enable = 1'b1;
        interval = 32'd100;
        t = cyc + 99;
        push(t + 262, base_avg, 4'hF, OVR_EN ? 32'd2 : 32'd0);
        push(t + 562, base_avg, 4'hF, OVR_EN ? 32'd3 : 32'd0);
        goto(t + 450);
        ctrl_enable = 1'b0;
        goto(t + 800);
        chk("drain2", 64'(q.size()), 64'd0);

        // reset during port2 divide, then a clean update
        reset = 1'b1;
        goto(cyc + 2);
        reset = 1'b0;
        ctrl_enable = 1'b1;
        interval = 32'd300;
        t = cyc + 299;
        goto(t + 150);
        chk("mid_valid", 64'(avg_valid), 64'(4'b0011));
        chk("mid_avg0", 64'(avg_rtt[31:0]), 64'd100);
        reset = 1'b1;
        goto(t + 151);
        chk("mrst_avg", 64'(avg_rtt[63:0]), 64'd0);
        chk("mrst_valid", 64'(avg_valid), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(update_done), 64'd0);
        chk("mrst_ovr", 64'(overrun_cnt), 64'd0);
        goto(t + 152);
        reset = 1'b0;
        t = cyc + 299;
        push(t + 262, base_avg, 4'hF, 32'd0);
        goto(t + 280);
        ctrl_enable = 1'b0;
        goto(t + 290);
        chk("drain3", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
